// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional trailing checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCountHi,
    StCountLo,
    StData,
    StCheck,
    StDone,
    StErr
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned COUNT_W        = 16;
  localparam logic [7:0]  CHK_INIT       = 8'h00;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes MSB first into n-bit words; word_valid fires combinationally
// on the final byte of each word so the caller can register the write.
module imem_word_packer #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         word_valid,
  output logic [n-1:0] word
);

  localparam int unsigned Bytes = n / 8;
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Bytes - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [n-9:0]    shift_q, shift_d;

  always_comb begin
    word       = {shift_q, byte_data};
    word_valid = byte_valid && (cnt_q == LastIdx);
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid) begin
      shift_d = word[n-9:0];
      cnt_d   = word_valid ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: count header, big-endian words, held status.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned n      = 32,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [n-1:0]      wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam logic [COUNT_W-1:0] DepthCnt = COUNT_W'(2 ** ADDR_W);

  state_e state_q, state_d;

  logic [7:0]         cnt_hi_q;
  logic [COUNT_W-1:0] count_full;
  logic [COUNT_W-1:0] rem_q;
  logic [ADDR_W-1:0]  idx_q;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [n-1:0]       wr_data_q;
  logic               fire, launch, data_fire;
  logic               word_valid;
  logic [n-1:0]       word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         chk_q;
`endif

  assign fire       = in_valid && in_ready;
  assign launch     = start && (state_q inside {StIdle, StDone, StErr});
  assign data_fire  = fire && (state_q == StData);
  assign count_full = {cnt_hi_q, in_data};

  imem_word_packer #(
    .n(n)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (launch),
    .byte_valid(data_fire),
    .byte_data (in_data),
    .word_valid(word_valid),
    .word      (word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StCountHi;
      end
      StCountHi: begin
        if (fire) state_d = StCountLo;
      end
      StCountLo: begin
        if (fire) begin
          if (count_full > DepthCnt) begin
            state_d = StErr;
          end else if (count_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        // Leave only once the final word's write strobe is on the bus.
        if (wr_en_q && (rem_q == '0)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (fire) state_d = (in_data == chk_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state_q)
      StCountHi, StCountLo: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StData: begin
        in_ready = (rem_q != '0);
        busy     = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      StDone: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      StErr: begin
        error = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_hi_q  <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= word_valid;
      if (word_valid) begin
        wr_data_q <= word;
        wr_addr_q <= idx_q;
        idx_q     <= idx_q + 1'b1;
        rem_q     <= rem_q - 1'b1;
      end
      if (launch) begin
        idx_q <= '0;
        rem_q <= '0;
      end
      if (fire && (state_q == StCountHi)) cnt_hi_q <= in_data;
      if (fire && (state_q == StCountLo)) rem_q <= count_full;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_q <= CHK_INIT;
    end else if (launch) begin
      chk_q <= CHK_INIT;
    end else if (data_fire) begin
      chk_q <= chk_q ^ in_data;
    end
  end
`endif

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; inputs change on falling edges, outputs sampled there too.
module tb_imem_loader;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 7;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_hold;

  int ntests = 0;
  int nfail  = 0;

  int            nw  = 0;
  int            nhs = 0;
  int            cyc = 0;
  logic [AW-1:0] wlog_addr[64];
  logic [N-1:0]  wlog_data[64];

  imem_loader #(
    .n     (N),
    .ADDR_W(AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .cpu_hold(cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (in_valid && in_ready) nhs = nhs + 1;
  end

  always @(negedge clk) begin
    if (wr_en && nw < 64) begin
      wlog_addr[nw] = wr_addr;
      wlog_data[nw] = wr_data;
      nw = nw + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present a byte and return at the falling edge after it was consumed.
  task automatic send_byte(input logic [7:0] b);
    int k;
    k        = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("hs_timeout", 64'(k), 64'd0);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i+:8]);
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  // Called in the final write cycle; ends in the first cycle after the stream completes.
  task automatic end_load(input logic [7:0] chk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(chk);
`else
    if (chk === 8'hxx) in_data = 8'h00;
    @(negedge clk);
`endif
    in_valid = 1'b0;
  endtask

  int c0, h0, wb;

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back load of three words.
    wb = nw;
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_hold", 64'(cpu_hold), 64'd1);
    c0 = cyc;
    h0 = nhs;
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(32'h8020000A, 1'b0);
    send_word(32'h04400800, 1'b0);
    send_word(32'h0C600800, 1'b0);
    in_valid = 1'b0;
    check("t1_cycles", 64'(cyc - c0), 64'd14);
    check("t1_handshakes", 64'(nhs - h0), 64'd14);
    check("t1_last_wr_en", 64'(wr_en), 64'd1);
    check("t1_last_addr", 64'(wr_addr), 64'd2);
    check("t1_last_data", 64'(wr_data), 64'h0C600800);
    check("t1_not_done_yet", 64'(done), 64'd0);
    end_load(8'h82);
    check("t1_done", 64'(done), 64'd1);
    check("t1_hold_rel", 64'(cpu_hold), 64'd0);
    check("t1_busy_off", 64'(busy), 64'd0);
    check("t1_wr_en_off", 64'(wr_en), 64'd0);
    check("t1_nwrites", 64'(nw - wb), 64'd3);
    check("t1_a0", 64'(wlog_addr[wb]), 64'd0);
    check("t1_d0", 64'(wlog_data[wb]), 64'h8020000A);
    check("t1_a1", 64'(wlog_addr[wb+1]), 64'd1);
    check("t1_d1", 64'(wlog_data[wb+1]), 64'h04400800);
    check("t1_a2", 64'(wlog_addr[wb+2]), 64'd2);
    check("t1_d2", 64'(wlog_data[wb+2]), 64'h0C600800);

    // Zero-length load.
    wb = nw;
    pulse_start();
    check("t2_restart_done_clr", 64'(done), 64'd0);
    check("t2_restart_hold", 64'(cpu_hold), 64'd1);
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    in_valid = 1'b0;
    check("t2_done", 64'(done), 64'd1);
    check("t2_error", 64'(error), 64'd0);
    check("t2_nwrites", 64'(nw - wb), 64'd0);

    // Oversize count, then recovery with a one-word load.
    wb = nw;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h81);
    in_valid = 1'b0;
    check("t3_error", 64'(error), 64'd1);
    check("t3_hold", 64'(cpu_hold), 64'd1);
    check("t3_done", 64'(done), 64'd0);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_nwrites", 64'(nw - wb), 64'd0);
    pulse_start();
    check("t3_err_clr", 64'(error), 64'd0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hDEADBEEF, 1'b0);
    in_valid = 1'b0;
    check("t3_wr_en", 64'(wr_en), 64'd1);
    check("t3_wr_addr", 64'(wr_addr), 64'd0);
    check("t3_wr_data", 64'(wr_data), 64'hDEADBEEF);
    end_load(8'h22);
    check("t3_done2", 64'(done), 64'd1);
    check("t3_error2", 64'(error), 64'd0);

    // Same three words with in_valid toggling every cycle.
    wb = nw;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(32'h8020000A, 1'b1);
    check("t4_w0_count", 64'(nw - wb), 64'd1);
    send_word(32'h04400800, 1'b1);
    check("t4_w1_count", 64'(nw - wb), 64'd2);
    send_word(32'h0C600800, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_nwrites", 64'(nw - wb), 64'd3);
    check("t4_d0", 64'(wlog_data[wb]), 64'h8020000A);
    check("t4_d1", 64'(wlog_data[wb+1]), 64'h04400800);
    check("t4_d2", 64'(wlog_data[wb+2]), 64'h0C600800);
    check("t4_a2", 64'(wlog_addr[wb+2]), 64'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h82);
    in_valid = 1'b0;
`endif
    check("t4_done", 64'(done), 64'd1);

    // Reset in the middle of the second word.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(32'h8020000A, 1'b0);
    send_byte(8'h04);
    send_byte(8'h40);
    wb = nw;
    rst = 1'b0;
    #1;
    check("t5_in_ready", 64'(in_ready), 64'd0);
    check("t5_wr_en", 64'(wr_en), 64'd0);
    check("t5_wr_addr", 64'(wr_addr), 64'd0);
    check("t5_wr_data", 64'(wr_data), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_error", 64'(error), 64'd0);
    check("t5_hold", 64'(cpu_hold), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_no_writes", 64'(nw - wb), 64'd0);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h11223344, 1'b0);
    in_valid = 1'b0;
    check("t5_new_addr", 64'(wr_addr), 64'd0);
    check("t5_new_data", 64'(wr_data), 64'h11223344);
    end_load(8'h44);
    check("t5_new_done", 64'(done), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Trailing checksum match and mismatch.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h0000000F, 1'b0);
    send_byte(8'h0F);
    in_valid = 1'b0;
    check("t6_chk_ok_done", 64'(done), 64'd1);
    check("t6_chk_ok_err", 64'(error), 64'd0);
    wb = nw;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h0000000F, 1'b0);
    send_byte(8'h0E);
    in_valid = 1'b0;
    check("t6_chk_bad_err", 64'(error), 64'd1);
    check("t6_chk_bad_hold", 64'(cpu_hold), 64'd1);
    check("t6_chk_bad_nw", 64'(nw - wb), 64'd1);
    check("t6_chk_bad_a0", 64'(wlog_addr[wb]), 64'd0);
    check("t6_chk_bad_d0", 64'(wlog_data[wb]), 64'h0000000F);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the writable instruction memory. It is the write side of the instruction memory interface that the fetch stage reads by PC. The block accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them sequentially from word address 0. It holds the processor in reset-hold (cpu_hold) until a load completes successfully.

Parameters:
n, 32, instruction word width; must be a multiple of 8 (BYTES = n/8).
ADDR_W, 7, word-address width; memory depth DEPTH = 2**ADDR_W (128 words, matching PC[8:2] indexing).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse that begins a load.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader accepts a byte this cycle.
wr_en  output  1  instruction memory write strobe, one cycle per word.
wr_addr  output  ADDR_W  word address; the byte address is {wr_addr,2'b00}.
wr_data  output  n  assembled instruction word.
busy  output  1  a load is in progress.
done  output  1  the last load completed; held.
error  output  1  the last load failed; held.
cpu_hold  output  1  keeps the pipeline stalled or in reset while 1.

Behaviour:
- Reset (rst=0, async): state=IDLE. in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=1. Internal counters clear. Memory contents are untouched. Reset mid-load aborts with no further writes.
- Handshake: a byte is consumed when in_valid && in_ready on a rising edge. in_ready=1 only in COUNT_HI, COUNT_LO, DATA and CHECK. in_data is ignored otherwise.
- States:
  - IDLE: on start -> COUNT_HI, busy=1.
  - COUNT_HI / COUNT_LO: these capture a 16-bit word count, MSB first. After COUNT_LO the next state is:
    - ERR if count > DEPTH;
    - DONE if count == 0 (or CHECK with the macro enabled);
    - DATA otherwise.
  - DATA: bytes are packed MSB first into the word. On the BYTES-th byte the word is complete. On the next cycle wr_en=1, wr_data=word, wr_addr=word index (write latency 1 cycle after the final byte handshake). The word index starts at 0 and increments after each write. After the count-th word the state moves to DONE (or CHECK). in_ready stays 1 during the write cycle, so back-to-back streaming at 1 byte/cycle is sustained.
  - DONE: done=1, busy=0, cpu_hold=0. It is entered only after the final wr_en cycle has issued.
  - ERR: error=1, busy=0, cpu_hold=1.
- start in DONE or ERR restarts the load: done and error clear, cpu_hold=1, state -> COUNT_HI. start in any other state is ignored.
- Counting: the word index never wraps. count == DEPTH writes addresses 0..DEPTH-1 exactly.
- in_valid gaps stall the current state indefinitely; there is no timeout.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Enabled: a running XOR of all data bytes (initialised to 8'h00 at COUNT_HI) is kept. After the last word the CHECK state accepts one trailing byte. A match goes to DONE; a mismatch goes to ERR (already-written words remain).
- Disabled: there is no CHECK state or checksum register, and the stream ends after the last data byte.

Decomposition:
- Package imem_loader_pkg holds the state encoding (IDLE, COUNT_HI, COUNT_LO, DATA, CHECK, DONE, ERR), BYTES_PER_WORD, COUNT_W=16 and CHK_INIT=8'h00.
- Sub-module imem_word_packer: the byte shift register plus byte counter. It emits word_valid and word on the BYTES-th accepted byte, with a synchronous clear input.

Test Plan:
- Load count=3 with bytes 80 20 00 0A, 04 40 08 00, 0C 60 08 00 streamed back-to-back -> three wr_en pulses: addr 0 = 32'h8020000A, addr 1 = 32'h04400800, addr 2 = 32'h0C600800; then done=1, cpu_hold=0. Total 14 byte handshakes with no stall.
- count=0 -> DONE immediately after COUNT_LO, with no wr_en pulse.
- count=16'h0081 (129 > 128) -> error=1, cpu_hold=1, no writes. A subsequent start followed by count=1 and a valid word -> done=1, error=0.
- in_valid toggled 1-0-1 every cycle during DATA -> words are identical to the back-to-back case, and wr_en fires once per 4 accepted bytes.
- rst asserted after the 2nd data byte of word 1 -> all outputs return to reset values immediately. A new load then writes starting from addr 0.
- With IMEM_LOADER_CHECKSUM_EN, count=1, word 00 00 00 0F and trailing byte 0F -> done. Trailing byte 0E -> error=1, with addr 0 already written as 32'h0000000F.
